// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: controller states,
// Booth digit encoding and the iteration-count rule.
package booth_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Booth digit chosen from one 3-bit multiplier window.
  typedef enum logic [2:0] {
    DIG_ZERO   = 3'd0,
    DIG_POS_M  = 3'd1,
    DIG_POS_2M = 3'd2,
    DIG_NEG_M  = 3'd3,
    DIG_NEG_2M = 3'd4
  } digit_e;

  // Iteration count for N-bit operands extended to N+2 bits: two
  // multiplier bits are retired per iteration.
  function automatic int booth_iters(input int n);
    return (n / 2) + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps the window {Q[1],Q[0],Q_1} onto a digit
// selecting 0, +/-M or +/-2M.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic [2:0] digit
);

  digit_e digit_s;

  // Window-to-digit lookup.
  always_comb begin
    digit_s = DIG_ZERO;
    case (window)
      3'b000, 3'b111: digit_s = DIG_ZERO;
      3'b001, 3'b010: digit_s = DIG_POS_M;
      3'b011:         digit_s = DIG_POS_2M;
      3'b100:         digit_s = DIG_NEG_2M;
      3'b101, 3'b110: digit_s = DIG_NEG_M;
      default:        digit_s = DIG_ZERO;
    endcase
  end

  assign digit = digit_s;

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both
// sides. Signed and unsigned operands share one datapath by extending both
// operands to N+2 bits at acceptance and always running N/2+1 iterations.
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int K  = booth_iters(N);
  localparam int CW = $clog2(K + 1);

  state_e           state_q,     state_d;
  logic [N+1:0]     m_q,         m_d;
  logic [N+1:0]     q_q,         q_d;
  logic             q1_q,        q1_d;
  logic [N+2:0]     acc_q,       acc_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [2*N-1:0]   product_q,   product_d;
  logic             out_valid_q, out_valid_d;

  logic [2:0]       digit_raw_s;
  digit_e           digit_s;
  logic [N+2:0]     addend_s;
  logic [N+2:0]     sum_s;
  logic [2*N+5:0]   full_s;
  logic [2*N+5:0]   shifted_s;
  logic [N+1:0]     a_ext_s;
  logic [N+1:0]     b_ext_s;

  booth_r4_encoder u_enc (
    .window ({q_q[1:0], q1_q}),
    .digit  (digit_raw_s)
  );

  assign digit_s = digit_e'(digit_raw_s);

  // Operand extension at acceptance: sign bit replicated only in signed mode.
  always_comb begin
    a_ext_s = {2'b00, a};
    b_ext_s = {2'b00, b};
    if (signed_mode) begin
      a_ext_s = {{2{a[N-1]}}, a};
      b_ext_s = {{2{b[N-1]}}, b};
    end else begin
      a_ext_s = {2'b00, a};
      b_ext_s = {2'b00, b};
    end
  end

  // One Booth step: add the selected multiple of M, then shift {ACC,Q,Q_1}
  // arithmetically right by two.
  always_comb begin
    addend_s = '0;
    case (digit_s)
      DIG_ZERO:   addend_s = '0;
      DIG_POS_M:  addend_s = {m_q[N+1], m_q};
      DIG_POS_2M: addend_s = {m_q, 1'b0};
      DIG_NEG_M:  addend_s = -{m_q[N+1], m_q};
      DIG_NEG_2M: addend_s = -{m_q, 1'b0};
      default:    addend_s = '0;
    endcase
    sum_s     = acc_q + addend_s;
    full_s    = {sum_s, q_q, q1_q};
    shifted_s = $signed(full_s) >>> 2;
  end

  // Next-state and datapath update; abort overrides every other transition.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    q_d         = q_q;
    q1_d        = q1_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = a_ext_s;
          q_d     = b_ext_s;
          q1_d    = 1'b0;
          acc_d   = '0;
          cnt_d   = CW'(K - 1);
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = shifted_s[2*N+5:N+3];
        q_d   = shifted_s[N+2:1];
        q1_d  = shifted_s[0];
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          product_d   = shifted_s[2*N:1];
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      m_q         <= '0;
      q_q         <= '0;
      q1_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      q_q         <= q_d;
      q1_q        <= q1_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench: directed N=8 scenarios and random back-to-back N=32
// traffic, compared against plain integer multiplication.
module tb_booth_radix4_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv8, ir8, sm8, ab8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv32, ir32, sm32, ab32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  int checks = 0;
  int errors = 0;

  booth_radix4_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .abort(ab8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(busy8)
  );

  booth_radix4_multiplier #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .signed_mode(sm32), .abort(ab32), .out_valid(ov32), .out_ready(or32),
    .product(p32), .busy(busy32)
  );

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    longint xe, ye;
    xe = sm ? longint'($signed(x)) : longint'(x);
    ye = sm ? longint'($signed(y)) : longint'(y);
    return 16'(xe * ye);
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic signed [63:0] xe, ye;
    xe = sm ? {{32{x[31]}}, x} : {32'h0, x};
    ye = sm ? {{32{y[31]}}, y} : {32'h0, y};
    return xe * ye;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one N=8 operation and wait for its result (out_ready untouched).
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                     output logic [15:0] p, output int lat);
    int guard;
    a8 = x; b8 = y; sm8 = sm; iv8 = 1'b1;
    guard = 0;
    while (!ir8 && guard < 50) begin tick(); guard++; end
    tick();
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
    lat = 0;
    while (!ov8 && lat < 50) begin tick(); lat++; end
    p = p8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
      errors++;
      $display("FAIL reset8: ir=%b ov=%b busy=%b p=%h required 1 0 0 0000", ir8, ov8, busy8, p8);
    end
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || busy32 !== 1'b0 || p32 !== 64'h0) begin
      errors++;
      $display("FAIL reset32: ir=%b ov=%b busy=%b p=%h required 1 0 0 0", ir32, ov32, busy32, p32);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed_min();
    logic [15:0] p;
    int lat;
    op8(8'h80, 8'h80, 1'b1, p, lat);
    checks++;
    if (p !== 16'h4000) begin errors++; $display("FAIL min_product: got %h required 4000", p); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL min_latency: got %0d required 5", lat); end
    checks++;
    if (ir8 !== 1'b0 || busy8 !== 1'b1) begin
      errors++; $display("FAIL done_ready: ir=%b busy=%b required 0 1", ir8, busy8);
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || p8 !== 16'h4000) begin
      errors++; $display("FAIL consume: ov=%b ir=%b p=%h required 0 1 4000", ov8, ir8, p8);
    end
  endtask

  task automatic test_modes();
    logic [15:0] p;
    int lat;
    op8(8'hFF, 8'hFF, 1'b0, p, lat);
    checks++;
    if (p !== 16'hFE01) begin errors++; $display("FAIL unsigned_ff: got %h required fe01", p); end
    or8 = 1'b1; tick(); or8 = 1'b0;
    op8(8'h7F, 8'hFF, 1'b1, p, lat);
    checks++;
    if (p !== 16'hFF81) begin errors++; $display("FAIL signed_7f_ff: got %h required ff81", p); end
    or8 = 1'b1; tick(); or8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] x, y;
      logic sm;
      x = 8'($urandom); y = 8'($urandom); sm = 1'($urandom);
      op8(x, y, sm, p, lat);
      checks++;
      if (p !== ref8(x, y, sm) || lat != 5) begin
        errors++;
        $display("FAIL rand8: %h*%h sm=%b got %h lat %0d required %h lat 5", x, y, sm, p, lat, ref8(x, y, sm));
      end
      or8 = 1'b1; tick(); or8 = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [15:0] p;
    int lat;
    int bad;
    op8(8'h5A, 8'hC3, 1'b1, p, lat);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1; end
      tick();
      iv8 = 1'b0;
      if (ov8 !== 1'b1 || p8 !== ref8(8'h5A, 8'hC3, 1'b1) || ir8 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall: %0d unstable cycles, last ov=%b p=%h ir=%b required 1 %h 0", bad, ov8, p8, ir8, ref8(8'h5A, 8'hC3, 1'b1));
    end
    or8 = 1'b1; tick(); or8 = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov8 !== 1'b0 || busy8 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_ignored: %0d cycles busy/valid required 0", bad); end
  endtask

  task automatic test_abort();
    logic [15:0] p;
    int lat;
    int bad;
    a8 = 8'h12; b8 = 8'h34; sm8 = 1'b1; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    ab8 = 1'b1;
    tick();
    ab8 = 1'b0;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL abort_idle: ir=%b ov=%b busy=%b required 1 0 0", ir8, ov8, busy8);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (ov8 !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_no_valid: %0d valid cycles required 0", bad); end
    op8(8'h03, 8'h05, 1'b1, p, lat);
    checks++;
    if (p !== 16'h000F) begin errors++; $display("FAIL after_abort: got %h required 000f", p); end
    // abort wins over out_ready and discards the result
    ab8 = 1'b1; or8 = 1'b1;
    tick();
    ab8 = 1'b0; or8 = 1'b0;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin errors++; $display("FAIL abort_done: ov=%b ir=%b required 0 1", ov8, ir8); end
    // abort wins over in_valid in IDLE
    ab8 = 1'b1; iv8 = 1'b1;
    tick();
    ab8 = 1'b0; iv8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || ir8 !== 1'b1) begin errors++; $display("FAIL abort_accept: busy=%b ir=%b required 0 1", busy8, ir8); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat;
    int bad;
    a8 = 8'h21; b8 = 8'h43; sm8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
      errors++; $display("FAIL reset_mid: ir=%b ov=%b busy=%b p=%h required 1 0 0 0000", ir8, ov8, busy8, p8);
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (ov8 !== 1'b0 || busy8 !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_no_valid: %0d bad cycles required 0", bad); end
    op8(8'h01, 8'hFF, 1'b1, p, lat);
    checks++;
    if (p !== 16'hFFFF) begin errors++; $display("FAIL after_reset: got %h required ffff", p); end
    or8 = 1'b1; tick(); or8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] corners [6];
    corners[0] = 32'h8000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h0000_0000; corners[4] = 32'h0000_0001; corners[5] = 32'h8000_0001;
    or32 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      logic sm;
      logic [63:0] got;
      int cyc, nvalid, guard;
      x = (i < 12) ? corners[i % 6] : $urandom;
      y = (i < 12) ? corners[(i / 2) % 6] : $urandom;
      sm = (i < 12) ? 1'(i % 2) : 1'($urandom);
      a32 = x; b32 = y; sm32 = sm; iv32 = 1'b1;
      guard = 0;
      while (!ir32 && guard < 50) begin tick(); guard++; end
      tick();
      iv32 = 1'b0;
      a32 = $urandom; b32 = $urandom;
      cyc = 0; nvalid = 0; got = '0;
      while (!ir32 && cyc < 60) begin
        tick();
        cyc++;
        if (ov32) begin nvalid++; got = p32; end
      end
      checks++;
      if (got !== ref32(x, y, sm) || nvalid != 1 || cyc != 18) begin
        errors++;
        $display("FAIL b2b: %h*%h sm=%b got %h valid %0d cycles %0d required %h valid 1 cycles 18", x, y, sm, got, nvalid, cyc, ref32(x, y, sm));
      end
    end
    or32 = 1'b0;
  endtask

  initial begin
    iv8 = 1'b0; sm8 = 1'b0; ab8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    iv32 = 1'b0; sm32 = 1'b0; ab32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
    test_reset();
    test_signed_min();
    test_modes();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
